trace_wb_capture: RTL and testbench
===================================

Name: trace_wb_capture

Overview:
- Upstream feeder for the per-core trace monitor.
- Taps the CPU retire/writeback interface and keeps a shadow copy of GPR r3 by snooping register-file writes.
- Packs {pc, insn, r3} for every retired instruction into a small FIFO. Drains the FIFO as a one-entry-per-cycle stream on enable/wb_pc/wb_insn/r3.
- Decouples monitor-side pausing from the core and flags lost entries.

Parameters:
- ID, 0, core identifier; reported in the overflow $display message.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- SHADOW_REG, 3, GPR index mirrored onto the r3 output.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- retire_valid  input  1  one instruction retires this cycle.
- retire_pc  input  32  PC of the retiring instruction.
- retire_insn  input  32  encoding of the retiring instruction.
- rf_we  input  1  register-file write strobe.
- rf_waddr  input  5  register-file write index.
- rf_wdata  input  32  register-file write data.
- hold  input  1  consumer pause; no pop while high.
- enable  output  1  output entry valid for exactly this cycle.
- wb_pc  output  32  PC of the output entry.
- wb_insn  output  32  instruction of the output entry.
- r3  output  32  shadow register value captured with the entry.
- overflow  output  1  sticky; an entry was dropped.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, rst=1):
  - FIFO pointers and level cleared.
  - Shadow register = 0.
  - enable, wb_pc, wb_insn, r3, overflow all 0.
  - Reset mid-operation discards all queued entries immediately.
- Shadow register:
  - On a clk edge with rf_we=1 and rf_waddr==SHADOW_REG, shadow <= rf_wdata.
  - Writes to any other index are ignored.
  - Writes occur independently of retire_valid.
- Capture value:
  - If retire_valid=1, the pushed r3 field = rf_wdata when rf_we=1 and rf_waddr==SHADOW_REG in that same cycle (bypass); otherwise it is the current shadow.
- Push: retire_valid=1 and (not full, or pop in same cycle) -> entry written at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop:
  - Occurs when level>0 and hold=0.
  - Registered outputs take the head entry; enable=1 for that cycle; rd_ptr increments modulo DEPTH.
  - Otherwise enable=0 and wb_pc/wb_insn/r3 hold their last values.
- Latency: with an empty FIFO and hold=0, an entry pushed at edge N appears with enable=1 after edge N+1 (one cycle). There is no bypass around the FIFO.
- level tracks pushes minus pops:
  - Simultaneous push and pop leaves level unchanged.
  - Simultaneous push and pop when full is accepted (no drop).
- Full (level==DEPTH) with retire_valid=1 and no pop:
  - Entry dropped; FIFO contents unchanged.
  - overflow <= 1, sticky until rst.
  - $display("[%t, %0d] trace FIFO overflow") once, on the first drop only.
- Empty with hold=0: enable=0; pointers unchanged.
- Pointer wrap: DEPTH power of two; pointers use log2(DEPTH)+1 bits; full/empty derived from the MSB compare.

Optional Feature:
- Macro: TRACE_WB_CAPTURE_DROP_CNT_EN.
- Defined:
  - Adds output drop_count [15:0], reset 0.
  - Increments once per dropped entry and saturates at 16'hFFFF.
  - overflow behaviour unchanged.
- Undefined: port absent; no counter logic.

Test Plan:
- Reset, then retire_valid for one cycle with pc=0x0000_2000, insn=0x1500_0004, rf_we=0, shadow=0 -> next cycle enable=1, wb_pc=0x2000, wb_insn=0x1500_0004, r3=0; level returns to 0.
- rf_we=1, rf_waddr=3, rf_wdata=0x41 in cycle N; retire_valid (l.nop 0x15000004) in N+1 -> output r3=0x41. Repeat with write and retire in the same cycle, rf_wdata=0x0A -> r3=0x0A (bypass). Write to rf_waddr=4 -> r3 unchanged.
- hold=1, DEPTH=4, retire 5 consecutive instructions pc=0x100..0x110 -> level=4, overflow=1 at the 5th, drop_count=1 (macro on); release hold -> 4 enable pulses with pc 0x100, 0x104, 0x108, 0x10C in order; 0x110 never output.
- FIFO full, hold=0, retire every cycle for 10 cycles -> no drops, overflow stays 0, level stays 4, pcs emitted strictly in order across pointer wrap.
- Assert rst for one cycle while level=3 -> enable=0, level=0, r3=0, overflow=0 in the same cycle; following retire of pc=0x200 appears after one cycle.
- Macro on: 70000 drops -> drop_count saturates at 0xFFFF.

Source files
------------

// File: rtl/trace_wb_capture.sv
// Retire-side trace capture: snoops a shadow GPR and buffers {pc, insn, reg} entries
// in a small FIFO drained one per cycle. Define TRACE_WB_CAPTURE_DROP_CNT_EN to add drop_count.
module trace_wb_capture #(
    parameter int ID         = 0,
    parameter int DEPTH      = 4,
    parameter int SHADOW_REG = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     retire_valid,
    input  logic [31:0]              retire_pc,
    input  logic [31:0]              retire_insn,
    input  logic                     rf_we,
    input  logic [4:0]               rf_waddr,
    input  logic [31:0]              rf_wdata,
    input  logic                     hold,
    output logic                     enable,
    output logic [31:0]              wb_pc,
    output logic [31:0]              wb_insn,
    output logic [31:0]              r3,
    output logic                     overflow,
`ifdef TRACE_WB_CAPTURE_DROP_CNT_EN
    output logic [15:0]              drop_count,
`endif
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    // Handshake: retire_valid has no back-pressure; an entry is accepted when the FIFO is not
    // full or a pop happens on the same edge, otherwise it is dropped. The consumer side pops
    // whenever data is queued and hold is low; enable marks the one cycle an entry is presented.

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [31:0]  shadow_q, shadow_d;
    logic         enable_q, enable_d;
    logic [31:0]  wb_pc_q, wb_pc_d;
    logic [31:0]  wb_insn_q, wb_insn_d;
    logic [31:0]  r3_q, r3_d;
    logic         overflow_q, overflow_d;

    logic [31:0]  pc_mem_q   [DEPTH];
    logic [31:0]  insn_mem_q [DEPTH];
    logic [31:0]  r3_mem_q   [DEPTH];

    logic         shadow_hit;
    logic [31:0]  cap_r3;
    logic         empty;
    logic         full;
    logic         pop;
    logic         push;
    logic         drop;

    assign shadow_hit = rf_we && (rf_waddr == 5'(SHADOW_REG));
    // Same-cycle write to the shadow index must be visible in the entry being retired.
    assign cap_r3     = shadow_hit ? rf_wdata : shadow_q;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && !hold;
    assign push  = retire_valid && (!full || pop);
    assign drop  = retire_valid && full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        shadow_d   = shadow_q;
        enable_d   = 1'b0;
        wb_pc_d    = wb_pc_q;
        wb_insn_d  = wb_insn_q;
        r3_d       = r3_q;
        overflow_d = overflow_q;

        if (shadow_hit) begin
            shadow_d = rf_wdata;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            enable_d  = 1'b1;
            wb_pc_d   = pc_mem_q[rd_ptr_q[AW-1:0]];
            wb_insn_d = insn_mem_q[rd_ptr_q[AW-1:0]];
            r3_d      = r3_mem_q[rd_ptr_q[AW-1:0]];
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            shadow_q   <= '0;
            enable_q   <= 1'b0;
            wb_pc_q    <= '0;
            wb_insn_q  <= '0;
            r3_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            shadow_q   <= shadow_d;
            enable_q   <= enable_d;
            wb_pc_q    <= wb_pc_d;
            wb_insn_q  <= wb_insn_d;
            r3_q       <= r3_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q[AW-1:0]]   <= retire_pc;
            insn_mem_q[wr_ptr_q[AW-1:0]] <= retire_insn;
            r3_mem_q[wr_ptr_q[AW-1:0]]   <= cap_r3;
        end
    end

`ifdef TRACE_WB_CAPTURE_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && drop && !overflow_q) begin
            $display("[%t, %0d] trace FIFO overflow", $time, ID);
        end
    end
`endif

    assign enable   = enable_q;
    assign wb_pc    = wb_pc_q;
    assign wb_insn  = wb_insn_q;
    assign r3       = r3_q;
    assign overflow = overflow_q;
    assign level    = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_trace_wb_capture.sv
// Directed bench for trace_wb_capture: shadow capture, hold/overflow, full streaming,
// asynchronous reset mid-stream and (with TRACE_WB_CAPTURE_DROP_CNT_EN) drop counter saturation.
module tb_trace_wb_capture;

    logic        clk;
    logic        rst;
    logic        retire_valid;
    logic [31:0] retire_pc;
    logic [31:0] retire_insn;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        hold;
    logic        enable;
    logic [31:0] wb_pc;
    logic [31:0] wb_insn;
    logic [31:0] r3;
    logic        overflow;
    logic [2:0]  level;
`ifdef TRACE_WB_CAPTURE_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    int checks;
    int failures;
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;

    localparam logic [31:0] NOP = 32'h1500_0004;

    trace_wb_capture #(.ID(0), .DEPTH(4), .SHADOW_REG(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .retire_valid (retire_valid),
        .retire_pc    (retire_pc),
        .retire_insn  (retire_insn),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .hold         (hold),
        .enable       (enable),
        .wb_pc        (wb_pc),
        .wb_insn      (wb_insn),
        .r3           (r3),
        .overflow     (overflow),
`ifdef TRACE_WB_CAPTURE_DROP_CNT_EN
        .drop_count   (drop_count),
`endif
        .level        (level)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rv, input logic [31:0] pc, input logic [31:0] insn,
                         input logic we, input logic [4:0] addr, input logic [31:0] data);
        retire_valid = rv;
        retire_pc    = pc;
        retire_insn  = insn;
        rf_we        = we;
        rf_waddr     = addr;
        rf_wdata     = data;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic do_reset();
        idle();
        hold = 1'b0;
        rst  = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (enable !== 1'b0) begin failures++; $display("FAIL reset_enable got=%b exp=0", enable); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (r3 !== 32'h0) begin failures++; $display("FAIL reset_r3 got=%h exp=0", r3); end
        checks++; if (wb_pc !== 32'h0) begin failures++; $display("FAIL reset_wb_pc got=%h exp=0", wb_pc); end
    endtask

    task automatic test_basic();
        drive(1'b1, 32'h0000_2000, NOP, 1'b0, 5'd0, 32'h0);
        step();
        idle();
        checks++; if (level !== 3'd1) begin failures++; $display("FAIL basic_level_after_push got=%0d exp=1", level); end
        checks++; if (enable !== 1'b0) begin failures++; $display("FAIL basic_no_bypass got=%b exp=0", enable); end
        step();
        checks++; if (enable !== 1'b1) begin failures++; $display("FAIL basic_enable got=%b exp=1", enable); end
        checks++; if (wb_pc !== 32'h0000_2000) begin failures++; $display("FAIL basic_pc got=%h exp=00002000", wb_pc); end
        checks++; if (wb_insn !== NOP) begin failures++; $display("FAIL basic_insn got=%h exp=%h", wb_insn, NOP); end
        checks++; if (r3 !== 32'h0) begin failures++; $display("FAIL basic_r3 got=%h exp=0", r3); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL basic_level_drained got=%0d exp=0", level); end
        step();
        checks++; if (enable !== 1'b0) begin failures++; $display("FAIL basic_enable_single got=%b exp=0", enable); end
        checks++; if (wb_pc !== 32'h0000_2000) begin failures++; $display("FAIL basic_pc_hold got=%h exp=00002000", wb_pc); end
    endtask

    task automatic test_shadow();
        // earlier write, later retire
        drive(1'b0, 32'h0, 32'h0, 1'b1, 5'd3, 32'h41);
        step();
        drive(1'b1, 32'h0000_3000, NOP, 1'b0, 5'd0, 32'h0);
        step();
        idle();
        step();
        checks++; if (r3 !== 32'h41) begin failures++; $display("FAIL shadow_prior_write got=%h exp=41", r3); end
        // write and retire on the same edge
        drive(1'b1, 32'h0000_3004, NOP, 1'b1, 5'd3, 32'h0A);
        step();
        idle();
        step();
        checks++; if (r3 !== 32'h0A) begin failures++; $display("FAIL shadow_bypass got=%h exp=0a", r3); end
        checks++; if (wb_pc !== 32'h0000_3004) begin failures++; $display("FAIL shadow_bypass_pc got=%h exp=00003004", wb_pc); end
        // write to another index is ignored
        drive(1'b1, 32'h0000_3008, NOP, 1'b1, 5'd4, 32'h99);
        step();
        drive(1'b1, 32'h0000_300C, NOP, 1'b0, 5'd0, 32'h0);
        step();
        idle();
        checks++; if (r3 !== 32'h0A) begin failures++; $display("FAIL shadow_other_idx got=%h exp=0a", r3); end
        step();
        checks++; if (r3 !== 32'h0A || wb_pc !== 32'h0000_300C) begin
            failures++; $display("FAIL shadow_other_idx_later got=%h/%h exp=0a/0000300c", r3, wb_pc);
        end
        step();
    endtask

    task automatic test_overflow();
        do_reset();
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h100 + 32'(i * 4), NOP, 1'b0, 5'd0, 32'h0);
            if (i < 4) exp_q.push_back(32'h100 + 32'(i * 4));
            step();
            if (i == 3) begin
                checks++; if (level !== 3'd4 || overflow !== 1'b0) begin
                    failures++; $display("FAIL ovf_fill got=%0d/%b exp=4/0", level, overflow);
                end
            end
        end
        idle();
        checks++; if (level !== 3'd4) begin failures++; $display("FAIL ovf_level got=%0d exp=4", level); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
`ifdef TRACE_WB_CAPTURE_DROP_CNT_EN
        checks++; if (drop_count !== 16'd1) begin failures++; $display("FAIL ovf_drop_count got=%0d exp=1", drop_count); end
`endif
        hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_pc = exp_q.pop_front();
            checks++; if (enable !== 1'b1 || wb_pc !== exp_pc) begin
                failures++; $display("FAIL ovf_drain%0d got=%b/%h exp=1/%h", i, enable, wb_pc, exp_pc);
            end
        end
        step();
        checks++; if (enable !== 1'b0 || level !== 3'd0) begin
            failures++; $display("FAIL ovf_no_extra got=%b/%0d exp=0/0", enable, level);
        end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h400 + 32'(i * 4), NOP, 1'b0, 5'd0, 32'h0);
            exp_q.push_back(32'h400 + 32'(i * 4));
            step();
        end
        hold = 1'b0;
        for (int i = 4; i < 14; i++) begin
            drive(1'b1, 32'h400 + 32'(i * 4), NOP, 1'b0, 5'd0, 32'h0);
            step();
            exp_pc = exp_q.pop_front();
            exp_q.push_back(32'h400 + 32'(i * 4));
            checks++; if (enable !== 1'b1 || wb_pc !== exp_pc || level !== 3'd4) begin
                failures++; $display("FAIL b2b_cycle%0d got=%b/%h/%0d exp=1/%h/4", i, enable, wb_pc, level, exp_pc);
            end
        end
        idle();
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_overflow got=%b exp=0", overflow); end
        for (int i = 0; i < 4; i++) begin
            step();
            exp_pc = exp_q.pop_front();
            checks++; if (enable !== 1'b1 || wb_pc !== exp_pc) begin
                failures++; $display("FAIL b2b_drain%0d got=%b/%h exp=1/%h", i, enable, wb_pc, exp_pc);
            end
        end
        step();
        checks++; if (level !== 3'd0 || enable !== 1'b0) begin
            failures++; $display("FAIL b2b_empty got=%0d/%b exp=0/0", level, enable);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1'b1, 32'h500, NOP, 1'b1, 5'd3, 32'h55);
        step();
        idle();
        step();
        checks++; if (r3 !== 32'h55 || enable !== 1'b1) begin
            failures++; $display("FAIL rstmid_setup got=%h/%b exp=55/1", r3, enable);
        end
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h600 + 32'(i * 4), NOP, 1'b0, 5'd0, 32'h0);
            step();
        end
        idle();
        checks++; if (level !== 3'd3) begin failures++; $display("FAIL rstmid_level3 got=%0d exp=3", level); end
        rst = 1'b1;
        #1;
        checks++; if (enable !== 1'b0 || level !== 3'd0 || r3 !== 32'h0 || overflow !== 1'b0) begin
            failures++; $display("FAIL rstmid_async got=%b/%0d/%h/%b exp=0/0/0/0", enable, level, r3, overflow);
        end
        @(posedge clk);
        #1;
        rst  = 1'b0;
        hold = 1'b0;
        drive(1'b1, 32'h200, NOP, 1'b0, 5'd0, 32'h0);
        step();
        idle();
        step();
        checks++; if (enable !== 1'b1 || wb_pc !== 32'h200 || r3 !== 32'h0) begin
            failures++; $display("FAIL rstmid_after got=%b/%h/%h exp=1/00000200/0", enable, wb_pc, r3);
        end
    endtask

`ifdef TRACE_WB_CAPTURE_DROP_CNT_EN
    task automatic test_drop_saturate();
        do_reset();
        hold = 1'b1;
        drive(1'b1, 32'h700, NOP, 1'b0, 5'd0, 32'h0);
        repeat (4 + 70000) step();
        idle();
        checks++; if (drop_count !== 16'hFFFF) begin failures++; $display("FAIL drop_saturate got=%h exp=ffff", drop_count); end
        checks++; if (level !== 3'd4 || overflow !== 1'b1) begin
            failures++; $display("FAIL drop_sat_state got=%0d/%b exp=4/1", level, overflow);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        hold     = 1'b0;
        idle();
        test_reset();
        test_basic();
        test_shadow();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
`ifdef TRACE_WB_CAPTURE_DROP_CNT_EN
        test_drop_saturate();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
